seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector for Din streams.
- Pattern is runtime-loadable; length, overlap policy, Moore/Mealy output style and counter width are set by parameters.
- Keeps a saturating count of matches.
- Drop-in successor to the fixed-pattern detectors; sits on the same serial Din path, with Din_valid added for gapped streams.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
MEALY, 0, 0 = Moore (registered Dout); 1 = Mealy (combinational Dout).
CNT_W, 8, match counter width; the counter saturates at 2^CNT_W-1.
RST_PAT, 4'b0110 (PAT_LEN bits), pattern value after reset.

Ports:
Clk  input  1  rising-edge clock.
Reset  input  1  asynchronous, active-high reset.
Din  input  1  serial data bit.
Din_valid  input  1  Din is sampled on the Clk edge only when this is 1.
Pat_load  input  1  load Pat_in on this Clk edge.
Pat_in  input  PAT_LEN  new pattern; MSB is the first bit expected.
Cnt_clr  input  1  synchronous clear of Match_cnt.
Dout  output  1  match pulse.
Match_cnt  output  CNT_W  number of matches, saturating.
Armed  output  1  history holds at least PAT_LEN-1 valid bits.

Behaviour:
- Reset (asynchronous, any time):
  - pattern_reg = RST_PAT; history = 0; fill = 0; Dout = 0; Match_cnt = 0; Armed = 0.
  - Reset mid-stream discards any partial match.
- State:
  - history: PAT_LEN-1 bits, shift register of the most recent valid bits; newest bit in the LSB.
  - fill: counter 0..PAT_LEN-1, saturating at PAT_LEN-1.
- Armed = (fill == PAT_LEN-1).
- hit (combinational) = Din_valid && Armed && ({history, Din} == pattern_reg).
- Each Clk edge with Din_valid=1 and Pat_load=0:
  - history shifts left, taking in Din.
  - fill increments, saturating.
  - Exception: if hit and OVERLAP=0, history and fill clear to 0 instead. The next match then needs PAT_LEN fresh bits.
- Din_valid=0: history, fill and pattern are held; no hit. Gaps do not break a partial match.
- Pat_load=1:
  - pattern_reg <= Pat_in; history and fill clear.
  - Pat_load has priority over Din_valid on the same edge; that Din is discarded and cannot produce a hit.
- Dout:
  - MEALY=1: Dout = hit, combinational in the same cycle the final bit is presented, before the edge.
  - MEALY=0: Dout is a register loaded with hit each edge. It goes high for exactly one cycle after the edge that sampled the final bit. Back-to-back overlapping hits (e.g. pattern 1111) give consecutive high cycles.
- Match_cnt:
  - Increments on each edge where hit=1 and it is below its maximum; it holds at 2^CNT_W-1.
  - Cnt_clr=1 sets it to 0 and takes priority over a simultaneous hit increment.
  - Cnt_clr does not affect history or Dout.
- Latency:
  - Moore: 1 cycle from the final-bit edge to Dout.
  - Mealy: 0 cycles.
  - Counter: updated on the final-bit edge.
- Width rules: the comparison is exactly PAT_LEN bits wide; Match_cnt is unsigned.

Decomposition:
- Package seq_det_pkg holds:
  - mode constants MODE_MOORE = 0, MODE_MEALY = 1;
  - OVL_ON = 1, OVL_OFF = 0;
  - function clog2 for sizing the fill counter.
- One sub-module, seq_sat_cnt (parametrised width; inputs inc and clr, clr dominant), instantiated for Match_cnt.

Test Plan:
- Moore, OVERLAP=1, RST_PAT 0110; Din stream 0,1,1,0,1,1,0 with Din_valid=1 -> Dout high one cycle after bits 4 and 7; Match_cnt = 2.
- Moore, OVERLAP=0, same stream -> Dout high only after bit 4; Match_cnt = 1; Armed deasserts after bit 4 and remains low until 3 further bits are sampled.
- Mealy, Pat_load 4'b1110; stream 1,1,1,1,0 -> Dout high combinationally during bit 5 (Din=0) only; Match_cnt = 1 after that edge; stream 1,1,1,0 with Din_valid low for 3 cycles between bits -> still one match.
- Pattern 1111, OVERLAP=1, Moore; eight 1s -> Dout high on 5 consecutive cycles; with CNT_W=2, Match_cnt saturates at 3; Cnt_clr together with a hit -> 0.
- Reset pulsed between bits 3 and 4 of 0110; Pat_load asserted together with the final bit -> no Dout; Match_cnt stays 0; Armed = 0.
- Random stream of 2000 bits over all OVERLAP/MEALY combinations and PAT_LEN in {2, 5, 16} -> Dout and Match_cnt match a behavioural model cycle for cycle.

Source files
------------

// File: rtl/seq_detect_param_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// The mode and overlap constants name the legal values of the MEALY and OVERLAP parameters.
package seq_det_pkg;

  localparam int MODE_MOORE = 0;
  localparam int MODE_MEALY = 1;
  localparam int OVL_OFF    = 0;
  localparam int OVL_ON     = 1;

  // Smallest bit count that can hold the values 0..value-1.
  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial data, pattern-load and status bundle of the pattern detector.
// The master side drives the stream; the slave side is the detector.
interface seq_detect_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               Din;
  logic               Din_valid;
  logic               Pat_load;
  logic [PAT_LEN-1:0] Pat_in;
  logic               Cnt_clr;
  logic               Dout;
  logic [CNT_W-1:0]   Match_cnt;
  logic               Armed;

  modport master (
    output Din, Din_valid, Pat_load, Pat_in, Cnt_clr,
    input  Dout, Match_cnt, Armed
  );

  modport slave (
    input  Din, Din_valid, Pat_load, Pat_in, Cnt_clr,
    output Dout, Match_cnt, Armed
  );
endinterface

// File: rtl/seq_detect_param_sat_cnt.sv
// Saturating up-counter with a synchronous clear that dominates the increment.
module seq_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, optional overlap,
// Moore or Mealy match pulse and a saturating match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter int                 OVERLAP = OVL_ON,
  parameter int                 MEALY   = MODE_MOORE,
  parameter int                 CNT_W   = 8,
  parameter logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(4'b0110)
) (
  input logic              Clk,
  input logic              Reset,
  seq_detect_param_if.slave bus
);

  localparam int                HIST_W   = PAT_LEN - 1;
  localparam int                FILL_W   = clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] r_pat;
  logic [HIST_W-1:0]  r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_dout;

  logic [PAT_LEN-1:0] w_pat_nxt;
  logic [HIST_W-1:0]  w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic [PAT_LEN-1:0] w_window;
  logic               w_armed;
  logic               w_take;
  logic               w_hit;

  // A load on the same edge swallows the incoming bit, so it can never complete a match.
  assign w_take   = bus.Din_valid && !bus.Pat_load;
  assign w_armed  = (r_fill == FILL_MAX);
  assign w_window = {r_hist, bus.Din};
  assign w_hit    = w_take && w_armed && (w_window == r_pat);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pat  <= RST_PAT;
      r_hist <= '0;
      r_fill <= '0;
      r_dout <= 1'b0;
    end else begin
      r_pat  <= w_pat_nxt;
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_dout <= w_hit;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold default first so no path leaves it unassigned (no latch).
    w_pat_nxt  = r_pat;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    if (bus.Pat_load) begin
      w_pat_nxt  = bus.Pat_in;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (bus.Din_valid) begin
      if (w_hit && (OVERLAP == OVL_OFF)) begin
        w_hist_nxt = '0;
        w_fill_nxt = '0;
      end else begin
        w_hist_nxt = w_window[HIST_W-1:0];
        if (!w_armed) w_fill_nxt = r_fill + FILL_W'(1);
      end
    end
  end

  assign bus.Dout  = (MEALY == MODE_MEALY) ? w_hit : r_dout;
  assign bus.Armed = w_armed;

  seq_sat_cnt #(
    .WIDTH (CNT_W)
  ) u_match_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (w_hit),
    .clr   (bus.Cnt_clr),
    .count (bus.Match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed scenarios on four fixed-config detectors plus a cycle-accurate
// comparison of twelve configurations against a behavioural model.
module tb_seq_detect_param;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Directed instances: 0 Moore/overlap, 1 Moore/no-overlap, 2 Mealy/overlap, 3 Moore/overlap CNT_W=2.
  logic       d_din = 1'b0, d_vld = 1'b0, d_load = 1'b0, d_clr = 1'b0;
  logic [3:0] d_pat = 4'b0000;
  logic [3:0] d_dout, d_armed;
  logic [3:0][7:0] d_cnt;

  for (genvar k = 0; k < 4; k++) begin : g_dir
    localparam int OV = (k == 1) ? OVL_OFF : OVL_ON;
    localparam int ML = (k == 2) ? MODE_MEALY : MODE_MOORE;
    localparam int CW = (k == 3) ? 2 : 8;
    seq_detect_param_if #(.PAT_LEN(4), .CNT_W(CW)) ifc ();
    assign ifc.Din       = d_din;
    assign ifc.Din_valid = d_vld;
    assign ifc.Pat_load  = d_load;
    assign ifc.Pat_in    = d_pat;
    assign ifc.Cnt_clr   = d_clr;
    assign d_dout[k]     = ifc.Dout;
    assign d_armed[k]    = ifc.Armed;
    assign d_cnt[k]      = 8'(ifc.Match_cnt);
    seq_detect_param #(
      .PAT_LEN(4), .OVERLAP(OV), .MEALY(ML), .CNT_W(CW), .RST_PAT(4'b0110)
    ) dut (
      .Clk(clk), .Reset(rst), .bus(ifc)
    );
  end

  // Random instances: PAT_LEN {2,5,16} x OVERLAP x MEALY, all fed the same stream.
  logic        r_din = 1'b0, r_vld = 1'b0, r_load = 1'b0, r_clr = 1'b0;
  logic [15:0] r_pat = 16'h0000;
  logic [11:0] dut_dout, exp_dout;
  logic [11:0][7:0] dut_cnt, exp_cnt;

  for (genvar g = 0; g < 12; g++) begin : g_rnd
    localparam int PL = (g < 4) ? 2 : ((g < 8) ? 5 : 16);
    localparam int OV = (g >> 1) & 1;
    localparam int ML = g & 1;
    seq_detect_param_if #(.PAT_LEN(PL), .CNT_W(8)) ifr ();
    assign ifr.Din       = r_din;
    assign ifr.Din_valid = r_vld;
    assign ifr.Pat_load  = r_load;
    assign ifr.Pat_in    = r_pat[PL-1:0];
    assign ifr.Cnt_clr   = r_clr;
    assign dut_dout[g]   = ifr.Dout;
    assign dut_cnt[g]    = ifr.Match_cnt;
    seq_detect_param #(
      .PAT_LEN(PL), .OVERLAP(OV), .MEALY(ML), .CNT_W(8)
    ) dut (
      .Clk(clk), .Reset(rst), .bus(ifr)
    );

    // Model: keep every recent bit and count bits seen since the last clear.
    logic [PL-1:0] m_pat;
    logic [15:0]   m_bits, m_next;
    int            m_seen;
    logic [7:0]    m_cnt;
    logic          m_dreg, m_hit;
    assign m_next = {m_bits[14:0], r_din};
    assign m_hit  = r_vld && !r_load && (m_seen >= PL - 1) && (m_next[PL-1:0] == m_pat);
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_pat <= '0; m_bits <= '0; m_seen <= 0; m_cnt <= '0; m_dreg <= 1'b0;
      end else begin
        m_dreg <= m_hit;
        if (r_clr) m_cnt <= '0;
        else if (m_hit && (m_cnt != 8'hFF)) m_cnt <= m_cnt + 8'd1;
        if (r_load) begin
          m_pat <= r_pat[PL-1:0]; m_bits <= '0; m_seen <= 0;
        end else if (r_vld) begin
          if (m_hit && (OV == 0)) begin
            m_bits <= '0; m_seen <= 0;
          end else begin
            m_bits <= m_next; m_seen <= m_seen + 1;
          end
        end
      end
    end
    assign exp_dout[g] = (ML == 1) ? m_hit : m_dreg;
    assign exp_cnt[g]  = m_cnt;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    d_din = 1'b0; d_vld = 1'b0; d_load = 1'b0; d_clr = 1'b0; d_pat = 4'b0000;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d_vld = 1'b1; d_din = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (d_dout[k] !== 1'b0) begin $display("FAIL reset_dout[%0d]: got %b want 0", k, d_dout[k]); fails++; end
      tests++;
      if (d_cnt[k] !== 8'd0) begin $display("FAIL reset_cnt[%0d]: got %0d want 0", k, d_cnt[k]); fails++; end
      tests++;
      if (d_armed[k] !== 1'b0) begin $display("FAIL reset_armed[%0d]: got %b want 0", k, d_armed[k]); fails++; end
      tests++;
    end
    rst = 1'b0; d_vld = 1'b0; d_din = 1'b0;
  endtask

  task automatic test_overlap();
    logic [6:0] stream  = 7'b0110110;
    logic [6:0] dout_a  = 7'b0001001;
    logic [6:0] dout_b  = 7'b0001000;
    logic [6:0] armed_a = 7'b0011111;
    logic [6:0] armed_b = 7'b0010001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      d_din = stream[6-i]; d_vld = 1'b1;
      tick();
      if (d_dout[0] !== dout_a[6-i]) begin $display("FAIL ovl_on_dout bit%0d: got %b want %b", i+1, d_dout[0], dout_a[6-i]); fails++; end
      tests++;
      if (d_dout[1] !== dout_b[6-i]) begin $display("FAIL ovl_off_dout bit%0d: got %b want %b", i+1, d_dout[1], dout_b[6-i]); fails++; end
      tests++;
      if (d_armed[0] !== armed_a[6-i]) begin $display("FAIL ovl_on_armed bit%0d: got %b want %b", i+1, d_armed[0], armed_a[6-i]); fails++; end
      tests++;
      if (d_armed[1] !== armed_b[6-i]) begin $display("FAIL ovl_off_armed bit%0d: got %b want %b", i+1, d_armed[1], armed_b[6-i]); fails++; end
      tests++;
    end
    if (d_cnt[0] !== 8'd2) begin $display("FAIL ovl_on_cnt: got %0d want 2", d_cnt[0]); fails++; end
    tests++;
    if (d_cnt[1] !== 8'd1) begin $display("FAIL ovl_off_cnt: got %0d want 1", d_cnt[1]); fails++; end
    tests++;
    d_vld = 1'b0;
    tick();
    if (d_dout[0] !== 1'b0) begin $display("FAIL ovl_on_pulse_width: got %b want 0", d_dout[0]); fails++; end
    tests++;
  endtask

  task automatic test_mealy();
    logic [4:0] s1 = 5'b11110;
    logic [3:0] s2 = 4'b1110;
    do_reset();
    d_load = 1'b1; d_pat = 4'b1110;
    tick();
    d_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_din = s1[4-i]; d_vld = 1'b1;
      #1;
      if (d_dout[2] !== (i == 4)) begin $display("FAIL mealy_dout bit%0d: got %b want %b", i+1, d_dout[2], (i == 4)); fails++; end
      tests++;
      tick();
    end
    if (d_cnt[2] !== 8'd1) begin $display("FAIL mealy_cnt: got %0d want 1", d_cnt[2]); fails++; end
    tests++;
    for (int i = 0; i < 4; i++) begin
      d_din = s2[3-i]; d_vld = 1'b1;
      #1;
      if (d_dout[2] !== (i == 3)) begin $display("FAIL gap_dout bit%0d: got %b want %b", i+1, d_dout[2], (i == 3)); fails++; end
      tests++;
      tick();
      for (int j = 0; j < 3 && i < 3; j++) begin
        d_din = 1'b0; d_vld = 1'b0;
        #1;
        if (d_dout[2] !== 1'b0) begin $display("FAIL gap_idle_dout bit%0d gap%0d: got %b want 0", i+1, j, d_dout[2]); fails++; end
        tests++;
        tick();
      end
    end
    if (d_cnt[2] !== 8'd2) begin $display("FAIL gap_cnt: got %0d want 2", d_cnt[2]); fails++; end
    tests++;
    d_vld = 1'b0;
  endtask

  task automatic test_saturate();
    logic [7:0] exp_c;
    do_reset();
    d_load = 1'b1; d_pat = 4'b1111;
    tick();
    d_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d_din = 1'b1; d_vld = 1'b1;
      tick();
      exp_c = (i < 3) ? 8'd0 : ((i - 2 > 3) ? 8'd3 : 8'(i - 2));
      if (d_dout[3] !== (i >= 3)) begin $display("FAIL ones_dout bit%0d: got %b want %b", i+1, d_dout[3], (i >= 3)); fails++; end
      tests++;
      if (d_cnt[3] !== exp_c) begin $display("FAIL sat_cnt bit%0d: got %0d want %0d", i+1, d_cnt[3], exp_c); fails++; end
      tests++;
    end
    if (d_cnt[0] !== 8'd5) begin $display("FAIL ones_cnt_wide: got %0d want 5", d_cnt[0]); fails++; end
    tests++;
    d_clr = 1'b1;
    tick();
    if (d_cnt[3] !== 8'd0) begin $display("FAIL clr_vs_hit_cnt: got %0d want 0", d_cnt[3]); fails++; end
    tests++;
    if (d_dout[3] !== 1'b1) begin $display("FAIL clr_keeps_dout: got %b want 1", d_dout[3]); fails++; end
    tests++;
    d_clr = 1'b0;
    tick();
    if (d_cnt[3] !== 8'd1) begin $display("FAIL after_clr_cnt: got %0d want 1", d_cnt[3]); fails++; end
    tests++;
    d_vld = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [2:0] head = 3'b011;
    do_reset();
    for (int i = 0; i < 3; i++) begin d_din = head[2-i]; d_vld = 1'b1; tick(); end
    if (d_armed[0] !== 1'b1) begin $display("FAIL pre_reset_armed: got %b want 1", d_armed[0]); fails++; end
    tests++;
    rst = 1'b1;
    #1;
    if (d_armed[0] !== 1'b0) begin $display("FAIL async_reset_armed: got %b want 0", d_armed[0]); fails++; end
    tests++;
    rst = 1'b0;
    #1;
    d_din = 1'b0; d_vld = 1'b1;
    #1;
    if (d_dout[2] !== 1'b0) begin $display("FAIL midreset_mealy_dout: got %b want 0", d_dout[2]); fails++; end
    tests++;
    tick();
    if (d_dout[0] !== 1'b0) begin $display("FAIL midreset_dout: got %b want 0", d_dout[0]); fails++; end
    tests++;
    if (d_cnt[0] !== 8'd0) begin $display("FAIL midreset_cnt: got %0d want 0", d_cnt[0]); fails++; end
    tests++;
    if (d_armed[0] !== 1'b0) begin $display("FAIL midreset_armed: got %b want 0", d_armed[0]); fails++; end
    tests++;
    do_reset();
    for (int i = 0; i < 3; i++) begin d_din = head[2-i]; d_vld = 1'b1; tick(); end
    d_din = 1'b0; d_vld = 1'b1; d_load = 1'b1; d_pat = 4'b0110;
    #1;
    if (d_dout[2] !== 1'b0) begin $display("FAIL load_final_mealy_dout: got %b want 0", d_dout[2]); fails++; end
    tests++;
    tick();
    d_load = 1'b0; d_vld = 1'b0;
    if (d_dout[0] !== 1'b0) begin $display("FAIL load_final_dout: got %b want 0", d_dout[0]); fails++; end
    tests++;
    if (d_cnt[0] !== 8'd0) begin $display("FAIL load_final_cnt: got %0d want 0", d_cnt[0]); fails++; end
    tests++;
    if (d_armed[0] !== 1'b0) begin $display("FAIL load_final_armed: got %b want 0", d_armed[0]); fails++; end
    tests++;
  endtask

  task automatic test_random();
    do_reset();
    r_load = 1'b1; r_pat = 16'hFFFB;
    tick();
    r_load = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      r_din  = ($urandom_range(7) != 0);
      r_vld  = ($urandom_range(3) != 0);
      r_load = ($urandom_range(63) == 0);
      r_clr  = ($urandom_range(127) == 0);
      #1;
      for (int g = 0; g < 12; g++) begin
        if (dut_dout[g] !== exp_dout[g]) begin $display("FAIL rnd_dout cfg%0d cyc%0d: got %b want %b", g, n, dut_dout[g], exp_dout[g]); fails++; end
        tests++;
        if (dut_cnt[g] !== exp_cnt[g]) begin $display("FAIL rnd_cnt cfg%0d cyc%0d: got %0d want %0d", g, n, dut_cnt[g], exp_cnt[g]); fails++; end
        tests++;
      end
      tick();
    end
    r_vld = 1'b0; r_load = 1'b0; r_clr = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_overlap();
    test_mealy();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
